sar_adc_ctrl: RTL

//   Successive-approximation ADC controller: the read-back direction of the 8-bit R2R DAC.

---
 rtl/sar_adc_pkg.sv | 16 +
 rtl/sar_adc_ctrl_sync.sv | 21 ++
 rtl/sar_adc_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and timing helpers for the SAR ADC controller.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE
  } state_t;

  // Cycles spent on one bit: settling, synchroniser latency, and the decide cycle.
  function automatic int unsigned bit_time(input int unsigned settle_cycles,
                                           input int unsigned sync_stages);
    return settle_cycles + sync_stages + 1;
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_sync.sv
// Reset-cleared flop chain bringing the asynchronous comparator output into clk.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the chain; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller driving an 8-bit R2R DAC and
// reading an external comparator, one bit per step, MSB first.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned T  = bit_time(SETTLE_CYCLES, SYNC_STAGES);
  localparam int unsigned CW = (T > 2) ? $clog2(T) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0]    CNT_LOAD = CW'(T - 2);
  localparam logic [BW-1:0]    BIT_TOP  = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cmp_sync;
  logic [WIDTH-1:0] final_code;
  logic [BW-1:0]    bit_dn;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (cmp_sync)
  );

  // State and datapath registers; everything returns to reset values on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= '0;
      result_q <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      result_q <= result_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath: settle, decide one bit, then load result or restart.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    result_d   = result_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    final_code = code_q;
    bit_dn     = bit_q - 1'b1;
    final_code[bit_q] = cmp_sync;

    unique case (state_q)
      IDLE: begin
        code_d = result_q;
        if (start || cont) begin
          code_d  = MSB_CODE;
          bit_d   = BIT_TOP;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = DECIDE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DECIDE: begin
        if (bit_q != '0) begin
          code_d         = final_code;
          code_d[bit_dn] = 1'b1;
          bit_d          = bit_dn;
          cnt_d          = CNT_LOAD;
          state_d        = SETTLE;
        end else begin
          result_d = final_code;
          done_d   = 1'b1;
          // Continuous mode reloads the MSB trial on the done edge, so the
          // ladder moves straight to the next conversion with no idle cycle.
          if (cont) begin
            code_d  = MSB_CODE;
            bit_d   = BIT_TOP;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            code_d  = final_code;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides any completion on the same edge.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      code_d   = result_q;
    end
  end

  assign dac_code = code_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule
